// File: rtl/fetch_data_buffer.sv
// ============================================================================
// fetch_data_buffer
//
// Sits downstream of the convolution address generator. Each accepted request
// carries an IFM byte address and a filter byte address; both SRAMs are read
// in lock-step and the returning words are parked as a pair in a small FIFO
// until the PE array takes them. A read is only issued when the FIFO is
// guaranteed to have room for its data, so PE backpressure simply throttles
// addr_ready and nothing is ever dropped.
//
// Parameters
//   DATA_WIDTH  SRAM word / PE data width
//   ADDR_WIDTH  request byte-address width
//   RD_LATENCY  SRAM read latency in cycles (1..4)
//   FIFO_DEPTH  pair-FIFO entries (power of 2, >= RD_LATENCY+1)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous clear of FIFO and in-flight reads
//   addr_valid/ready   request handshake; ifm_addr, filter_addr byte addresses
//   mem_ifm_*          IFM SRAM read strobe, word address, read data
//   mem_flt_*          filter SRAM read strobe, word address, read data
//   pe_valid/ready     head-of-FIFO handshake towards the PE array
//   pe_ifm_data        head IFM word
//   pe_filter_data     head filter word
//   occupancy          number of pairs held in the FIFO
//   busy               reads in flight or FIFO non-empty
// ============================================================================
module fetch_data_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          addr_valid,
    output logic                          addr_ready,
    input  logic [ADDR_WIDTH-1:0]         ifm_addr,
    input  logic [ADDR_WIDTH-1:0]         filter_addr,
    output logic                          mem_ifm_rd_en,
    output logic [ADDR_WIDTH-3:0]         mem_ifm_addr,
    input  logic [DATA_WIDTH-1:0]         mem_ifm_rdata,
    output logic                          mem_flt_rd_en,
    output logic [ADDR_WIDTH-3:0]         mem_flt_addr,
    input  logic [DATA_WIDTH-1:0]         mem_flt_rdata,
    output logic                          pe_valid,
    input  logic                          pe_ready,
    output logic [DATA_WIDTH-1:0]         pe_ifm_data,
    output logic [DATA_WIDTH-1:0]         pe_filter_data,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    // Wide enough to hold occupancy + inflight without overflow.
    localparam int SUM_W = OCC_W + 1;

    logic [RD_LATENCY-1:0]   rd_pipe;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [2*DATA_WIDTH-1:0] storage [FIFO_DEPTH];

    logic [SUM_W-1:0] inflight;
    logic [SUM_W-1:0] credit_used;
    logic             acc;
    logic             push;
    logic             pop;
    logic             unused_addr_bits;

    // Word addresses drop the byte offset; the two low bits are don't-care.
    assign mem_ifm_addr     = ifm_addr[ADDR_WIDTH-1:2];
    assign mem_flt_addr     = filter_addr[ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^{ifm_addr[1:0], filter_addr[1:0]};

    // Count reads that have been issued but whose data has not been written
    // into the FIFO yet, and decide whether one more read can be afforded.
    // A pop in the current cycle is deliberately not credited until the
    // following cycle so that pe_ready never reaches addr_ready.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SUM_W'(rd_pipe[i]);
        end
        credit_used = SUM_W'(occupancy) + inflight;
        addr_ready  = rst_n & ~flush & (credit_used < SUM_W'(FIFO_DEPTH));
    end

    assign acc           = addr_valid & addr_ready;
    assign mem_ifm_rd_en = acc;
    assign mem_flt_rd_en = acc;

    // The oldest bit of the shift register marks the cycle in which SRAM data
    // for a past accept is on the read buses. Flush wins over push and pop.
    assign push = rd_pipe[RD_LATENCY-1] & ~flush;
    assign pe_valid = (occupancy != '0);
    assign pop  = pe_valid & pe_ready & ~flush;

    assign pe_ifm_data    = storage[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
    assign pe_filter_data = storage[rd_ptr][DATA_WIDTH-1:0];

    assign busy = (occupancy != '0) | (|rd_pipe);

    // Control state: the in-flight shift register, both FIFO pointers and the
    // occupancy counter. Reset and flush both wipe everything, which is what
    // makes late SRAM returns harmless: with the shift register cleared no
    // push is ever scheduled for them. Pointers wrap for free because the
    // depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rd_pipe   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            rd_pipe[0] <= acc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Pair storage. No reset is needed: an entry is only ever read after it
    // has been written, and pe_valid gates the head for the consumer.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= {mem_ifm_rdata, mem_flt_rdata};
        end
    end

    // The credit scheme must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && occupancy == OCC_W'(FIFO_DEPTH)));

endmodule
